// File: rtl/hsi_byte_rx_pkg.sv
// Shared definitions for the HSI serial receive front end: default timing,
// parity sense, FSM state encoding and the per-byte parity check.
package hsi_byte_rx_pkg;

    localparam int HSI_BIT_CLKS   = 16;
    localparam int HSI_GAP_BITS   = 4;
    localparam bit HSI_PARITY_ODD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // True when data plus parity bit does not give the expected total parity.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit,
                                             input logic       odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input. The reset
// value is an input so idle-high lines can come out of reset already idle.
module sync_2ff (
    input  logic clk,
    input  logic n_rst,
    input  logic rst_val,
    input  logic din,
    output logic dout
);

    logic stage1_reg;
    logic stage2_reg;

    // Two back-to-back flops to settle metastability on din.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage1_reg <= rst_val;
            stage2_reg <= rst_val;
        end else begin
            stage1_reg <= din;
            stage2_reg <= stage1_reg;
        end
    end

    assign dout = stage2_reg;

endmodule

// File: rtl/hsi_byte_rx.sv
// HSI serial byte receiver: start, 8 data bits LSB first, parity, stop.
// Emits each byte on d/d_rdy with a parity flag, flags framing errors and
// marks the end of a message once the line has been idle for GAP_BITS bits.
module hsi_byte_rx
    import hsi_byte_rx_pkg::*;
#(
    parameter int BIT_CLKS   = HSI_BIT_CLKS,
    parameter int GAP_BITS   = HSI_GAP_BITS,
    parameter bit PARITY_ODD = HSI_PARITY_ODD
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx,
    output logic [7:0] d,
    output logic       d_rdy,
    output logic       pb_err,
    output logic       frm_err,
    output logic       rx_msg_end,
    output logic       rx_busy
);

    localparam int BC_W = $clog2(BIT_CLKS);
    localparam int GC_W = $clog2(GAP_BITS * BIT_CLKS) + 1;

    localparam logic [BC_W-1:0] BC_MID  = BC_W'(BIT_CLKS / 2);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CLKS - 1);
    // The pulse fires on the clock where gc would step onto the terminal
    // count, so the compare is one below it and gc never holds that value.
    localparam logic [GC_W-1:0] GC_PRE  = GC_W'(GAP_BITS * BIT_CLKS - 2);

    logic            rx_s;
    logic            rx_s_d_reg;
    logic            fall;
    rx_state_t       state_reg;
    logic [BC_W-1:0] bc_reg;
    logic [2:0]      bi_reg;
    logic [7:0]      shreg_reg;
    logic            par_bit_reg;
    logic [GC_W-1:0] gc_reg;
    logic            msg_active_reg;

    sync_2ff u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .rst_val (1'b1),
        .din     (rx),
        .dout    (rx_s)
    );

    // Delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_s_d_reg <= 1'b1;
        end else begin
            rx_s_d_reg <= rx_s;
        end
    end

    assign fall = rx_s_d_reg & ~rx_s;

    // Frame FSM, registered outputs and the inter-byte idle gap counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_IDLE;
            bc_reg         <= '0;
            bi_reg         <= '0;
            shreg_reg      <= '0;
            par_bit_reg    <= 1'b0;
            gc_reg         <= '0;
            msg_active_reg <= 1'b0;
            d              <= '0;
            d_rdy          <= 1'b0;
            pb_err         <= 1'b0;
            frm_err        <= 1'b0;
            rx_msg_end     <= 1'b0;
            rx_busy        <= 1'b0;
        end else begin
            d_rdy      <= 1'b0;
            pb_err     <= 1'b0;
            frm_err    <= 1'b0;
            rx_msg_end <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (fall) begin
                        state_reg <= ST_START;
                        bc_reg    <= '0;
                        rx_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bc_reg == BC_MID) begin
                        bc_reg <= '0;
                        if (!rx_s) begin
                            bi_reg    <= '0;
                            state_reg <= ST_DATA;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            state_reg <= ST_IDLE;
                            rx_busy   <= 1'b0;
                        end
                    end else begin
                        bc_reg <= bc_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bc_reg == BC_LAST) begin
                        bc_reg            <= '0;
                        shreg_reg[bi_reg] <= rx_s;
                        if (bi_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end else begin
                            bi_reg <= bi_reg + 1'b1;
                        end
                    end else begin
                        bc_reg <= bc_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bc_reg == BC_LAST) begin
                        bc_reg      <= '0;
                        par_bit_reg <= rx_s;
                        state_reg   <= ST_STOP;
                    end else begin
                        bc_reg <= bc_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bc_reg == BC_LAST) begin
                        bc_reg  <= '0;
                        rx_busy <= 1'b0;
                        if (rx_s) begin
                            d              <= shreg_reg;
                            d_rdy          <= 1'b1;
                            pb_err         <= parity_mismatch(shreg_reg, par_bit_reg, PARITY_ODD);
                            msg_active_reg <= 1'b1;
                            state_reg      <= ST_IDLE;
                        end else begin
                            // Byte discarded; wait for the line to recover.
                            frm_err   <= 1'b1;
                            state_reg <= ST_BREAK;
                        end
                    end else begin
                        bc_reg <= bc_reg + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    bc_reg    <= '0;
                    rx_busy   <= 1'b0;
                end
            endcase

            // Gap counting only runs on a quiet idle line inside a message;
            // a falling edge on the terminal clock wins over the pulse.
            if (state_reg != ST_IDLE || fall || d_rdy) begin
                gc_reg <= '0;
            end else if (msg_active_reg) begin
                if (gc_reg == GC_PRE) begin
                    gc_reg         <= '0;
                    rx_msg_end     <= 1'b1;
                    msg_active_reg <= 1'b0;
                end else begin
                    gc_reg <= gc_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hsi_byte_rx.sv
// Directed bench for hsi_byte_rx with BIT_CLKS=16, GAP_BITS=4, odd parity.
module tb_hsi_byte_rx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rx;
    logic [7:0] d;
    logic       d_rdy;
    logic       pb_err;
    logic       frm_err;
    logic       rx_msg_end;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Event monitor state (updated on negedge, read by the stimulus thread)
    int         cyc     = 0;
    int         n_rdy   = 0;
    int         n_frm   = 0;
    int         n_end   = 0;
    int         n_bad   = 0;
    int         rdy_cyc = 0;
    int         end_cyc = 0;
    logic [7:0] rdy_d   = 8'h00;
    logic       rdy_pb  = 1'b0;
    logic [7:0] end_d   = 8'h00;

    int start_cyc = 0;
    int s_rdy, s_frm, s_end;

    hsi_byte_rx #(
        .BIT_CLKS   (16),
        .GAP_BITS   (4),
        .PARITY_ODD (1'b1)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .d          (d),
        .d_rdy      (d_rdy),
        .pb_err     (pb_err),
        .frm_err    (frm_err),
        .rx_msg_end (rx_msg_end),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_rdy) begin
            n_rdy   <= n_rdy + 1;
            rdy_d   <= d;
            rdy_pb  <= pb_err;
            rdy_cyc <= cyc;
        end
        if (frm_err) n_frm <= n_frm + 1;
        if (rx_msg_end) begin
            n_end   <= n_end + 1;
            end_cyc <= cyc;
            end_d   <= d;
        end
        if ((d_rdy && rx_msg_end) || (pb_err && !d_rdy)) n_bad <= n_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One full frame: start, data LSB first, parity, stop (16 clk per bit)
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        logic [10:0] f;
        f = {stp, par, b, 1'b0};
        start_cyc = cyc + 1;
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic snap();
        s_rdy = n_rdy;
        s_frm = n_frm;
        s_end = n_end;
    endtask

    initial begin
        n_rst = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("reset_outputs_in_reset", {24'h0, d, d_rdy, pb_err, frm_err, rx_msg_end, rx_busy}, 32'h0);
        n_rst = 1'b1;
        idle(100);
        check("reset_outputs_after", {24'h0, d, d_rdy, pb_err, frm_err, rx_msg_end, rx_busy}, 32'h0);
        check("no_msg_end_after_reset", n_end, 0);

        // 1. 0xA5 with correct odd parity
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);
        check("t1_rdy_count", n_rdy - s_rdy, 1);
        check("t1_d", rdy_d, 8'hA5);
        check("t1_pb_err", rdy_pb, 1'b0);
        check("t1_latency", rdy_cyc - start_cyc, 171);
        idle(100);
        check("t1_msg_end_count", n_end - s_end, 1);

        // 2. 0x3C with wrong parity (0), then with correct parity (1)
        snap();
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(20);
        check("t2_bad_d", rdy_d, 8'h3C);
        check("t2_bad_pb_err", rdy_pb, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        check("t2_good_pb_err", rdy_pb, 1'b0);
        check("t2_rdy_count", n_rdy - s_rdy, 2);
        idle(100);

        // 3. Four back-to-back bytes then idle
        snap();
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h80, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(300);
        check("t3_rdy_count", n_rdy - s_rdy, 4);
        check("t3_last_d", rdy_d, 8'hC3);
        check("t3_last_pb_err", rdy_pb, 1'b0);
        check("t3_msg_end_count", n_end - s_end, 1);
        check("t3_gap_clks", end_cyc - rdy_cyc, 64);
        check("t3_d_at_msg_end", end_d, 8'hC3);

        // 4. 5-clk glitch on idle line
        snap();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t4_busy_during_glitch", rx_busy, 1'b1);
        rx = 1'b1;
        idle(200);
        check("t4_rdy_count", n_rdy - s_rdy, 0);
        check("t4_frm_count", n_frm - s_frm, 0);
        check("t4_msg_end_count", n_end - s_end, 0);
        check("t4_busy_after", rx_busy, 1'b0);

        // 5. Stop bit low outside a message, then a good byte, then a
        //    framing error inside the open message
        snap();
        send_frame(8'h55, 1'b1, 1'b0);
        rx = 1'b1;
        idle(100);
        check("t5_frm_count", n_frm - s_frm, 1);
        check("t5_no_rdy", n_rdy - s_rdy, 0);
        check("t5_d_unchanged", d, 8'hC3);
        check("t5_no_msg_end", n_end - s_end, 0);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(10);
        check("t5_rdy_count", n_rdy - s_rdy, 1);
        check("t5_d", rdy_d, 8'h01);
        check("t5_pb_err", rdy_pb, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        rx = 1'b1;
        idle(150);
        check("t5_frm_mid_msg", n_frm - s_frm, 2);
        check("t5_msg_end_after_break", n_end - s_end, 1);

        // 6. Reset during data bit 4 with a message open
        send_frame(8'h12, 1'b1, 1'b1);
        rx = 1'b0;
        repeat (16 * 5 + 8) @(negedge clk);
        #1;
        check("t6_busy_before_reset", rx_busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("t6_outputs_in_reset", {24'h0, d, d_rdy, pb_err, frm_err, rx_msg_end, rx_busy}, 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        snap();
        idle(100);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(10);
        check("t6_rdy_count", n_rdy - s_rdy, 1);
        check("t6_d", rdy_d, 8'hFF);
        check("t6_pb_err", rdy_pb, 1'b0);
        check("t6_no_msg_end_before_byte", n_end - s_end, 0);
        idle(100);
        check("t6_msg_end_after_byte", n_end - s_end, 1);

        check("no_illegal_pulse_overlap", n_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
